xsw_rsp_steer: RTL and testbench

- Return-path companion to the switch's round-robin request arbiter.
- Records the one-hot grant of every accepted request in an in-order tracking FIFO.
- Steers the single target's response stream back to the initiator at the FIFO head.
- Sits at the target port of the switch, between the target's response channel and the per-initiator response channels.

---
 rtl/xsw_rsp_steer.sv | 140 ++++++++++++++
 tb/tb_xsw_rsp_steer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/xsw_rsp_steer.sv
// xsw_rsp_steer: return-path steering for a single switch target port.
// Accepted request grants are queued in order. The target response stream is
// steered to the initiator at the queue head.
// Optional macro XSW_RSP_MULTIBEAT_EN adds multi-beat responses (t_rsp_last,
// i_rsp_last, beat_cnt). Only the last beat of a response pops the head.

// Per-initiator steering slice: forward valid to this initiator when it owns the
// head, and report its ready back when it owns the head.
module xsw_rsp_lane (
  input  logic head,
  input  logic rsp_live,
  input  logic rdy,
  output logic vld,
  output logic take
);
  assign vld  = head & rsp_live;
  assign take = head & rdy;
endmodule

module xsw_rsp_steer #(
  parameter int N  = 4,
  parameter int D  = 4,
  parameter int DW = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   acc_valid,
  input  logic [N-1:0]           acc_gnt,
  output logic                   ord_full,
  output logic                   ord_empty,
  output logic [$clog2(D+1)-1:0] ord_cnt,
  input  logic                   t_rsp_valid,
  output logic                   t_rsp_ready,
  input  logic [DW-1:0]          t_rsp_data,
  output logic [N-1:0]           i_rsp_valid,
  input  logic [N-1:0]           i_rsp_ready,
  output logic [DW-1:0]          i_rsp_data,
  output logic                   err_ovf,
  output logic                   err_orphan
`ifdef XSW_RSP_MULTIBEAT_EN
  ,
  input  logic                   t_rsp_last,
  output logic [N-1:0]           i_rsp_last,
  output logic [15:0]            beat_cnt
`endif
);
  localparam int AW = $clog2(D);
  localparam int CW = $clog2(D+1);

  logic [D-1:0][N-1:0] ord_mem;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       cnt;
  logic [N-1:0]        head, take;
  logic                rsp_live, push, hs, pop;

  // Status flags come from the registered count only. This keeps a same-cycle
  // push from being visible at the head.
  assign ord_full  = (cnt == CW'(D));
  assign ord_empty = (cnt == '0);
  assign ord_cnt   = cnt;

  assign head     = ord_mem[rd_ptr];
  assign rsp_live = t_rsp_valid & ~ord_empty;
  assign push     = acc_valid & ~ord_full;
  assign hs       = t_rsp_valid & t_rsp_ready;
`ifdef XSW_RSP_MULTIBEAT_EN
  assign pop      = hs & t_rsp_last;
  assign i_rsp_last = i_rsp_valid & {N{t_rsp_last}};
`else
  assign pop      = hs;
`endif

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_lane
      xsw_rsp_lane u_lane (
        .head    (head[g]),
        .rsp_live(rsp_live),
        .rdy     (i_rsp_ready[g]),
        .vld     (i_rsp_valid[g]),
        .take    (take[g])
      );
    end
  endgenerate

  // Only the head initiator's ready matters. Other initiators' ready inputs are ignored.
  assign t_rsp_ready = ~ord_empty & (|take);
  assign i_rsp_data  = t_rsp_data;

  // Grant storage. Contents are don't-care after reset, so this block has no reset.
  always_ff @(posedge clk) begin
    if (push) ord_mem[wr_ptr] <= acc_gnt;
  end

  // Pointers and occupancy. Pointers wrap naturally because D is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky protocol error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_ovf    <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      if (acc_valid & ord_full)             err_ovf    <= 1'b1;
      if (t_rsp_valid & ord_empty & ~push)  err_orphan <= 1'b1;
    end
  end

`ifdef XSW_RSP_MULTIBEAT_EN
  // Beat counter for the current response. It clears on the last beat and saturates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      beat_cnt <= '0;
    else if (hs & t_rsp_last)       beat_cnt <= '0;
    else if (hs && beat_cnt != '1)  beat_cnt <= beat_cnt + 16'd1;
  end
`endif

`ifndef SYNTHESIS
  // Simulation-only sanity checks on the grant input and the steering output.
  always_ff @(posedge clk) begin
    if (rstn && acc_valid) assert ($onehot(acc_gnt)) else $error("acc_gnt not one-hot");
    if (rstn) assert ($onehot0(i_rsp_valid)) else $error("i_rsp_valid not onehot0");
  end
`endif

endmodule

// File: tb/tb_xsw_rsp_steer.sv
// Randomized, self-checking bench for xsw_rsp_steer (default build).
// The reference is a queue of grants plus two sticky flags.
module tb_xsw_rsp_steer;
  localparam int N = 4, D = 4, DW = 32;

  logic          clk = 1'b0, rstn;
  logic          acc_valid;
  logic [N-1:0]  acc_gnt;
  logic          ord_full, ord_empty;
  logic [2:0]    ord_cnt;
  logic          t_rsp_valid, t_rsp_ready;
  logic [DW-1:0] t_rsp_data, i_rsp_data;
  logic [N-1:0]  i_rsp_valid, i_rsp_ready;
  logic          err_ovf, err_orphan;

  int n_tests = 0, n_fail = 0;

  logic [N-1:0] q[$];
  bit m_ovf, m_orph;

  xsw_rsp_steer #(.N(N), .D(D), .DW(DW)) dut (
    .clk(clk), .rstn(rstn),
    .acc_valid(acc_valid), .acc_gnt(acc_gnt),
    .ord_full(ord_full), .ord_empty(ord_empty), .ord_cnt(ord_cnt),
    .t_rsp_valid(t_rsp_valid), .t_rsp_ready(t_rsp_ready), .t_rsp_data(t_rsp_data),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
    .err_ovf(err_ovf), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model for the current inputs
  task automatic check_outputs();
    logic [N-1:0] hd, exp_iv;
    bit empty, exp_tr;
    empty  = (q.size() == 0);
    hd     = empty ? '0 : q[0];
    exp_iv = (t_rsp_valid && !empty) ? hd : '0;
    exp_tr = !empty && ((hd & i_rsp_ready) != 0);
    chk("ord_cnt",    64'(ord_cnt),    64'(q.size()));
    chk("ord_empty",  64'(ord_empty),  64'(empty));
    chk("ord_full",   64'(ord_full),   64'(q.size() == D));
    chk("i_rsp_valid",64'(i_rsp_valid),64'(exp_iv));
    chk("t_rsp_ready",64'(t_rsp_ready),64'(exp_tr));
    chk("i_rsp_data", 64'(i_rsp_data), 64'(t_rsp_data));
    chk("err_ovf",    64'(err_ovf),    64'(m_ovf));
    chk("err_orphan", 64'(err_orphan), 64'(m_orph));
  endtask

  // One clock: drive, check, then advance the model by what the coming edge does
  task automatic cycle(input bit av, input logic [N-1:0] gnt, input bit tv,
                       input logic [DW-1:0] d, input logic [N-1:0] rdy);
    bit empty, full, push, pop;
    @(negedge clk);
    acc_valid = av; acc_gnt = gnt; t_rsp_valid = tv; t_rsp_data = d; i_rsp_ready = rdy;
    #1;
    check_outputs();
    empty = (q.size() == 0);
    full  = (q.size() == D);
    push  = av && !full;
    pop   = tv && !empty && ((q[0] & rdy) != 0);
    if (av && full) m_ovf = 1'b1;
    if (tv && empty && !push) m_orph = 1'b1;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(gnt);
  endtask

  task automatic idle_inputs();
    acc_valid = 0; acc_gnt = '0; t_rsp_valid = 0; t_rsp_data = '0; i_rsp_ready = '0;
  endtask

  // Asynchronous reset applied between clock edges
  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    q.delete(); m_ovf = 0; m_orph = 0;
    check_outputs();
    idle_inputs();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  function automatic logic [N-1:0] rnd_gnt();
    logic [N-1:0] one = 1;
    return one << $urandom_range(0, N-1);
  endfunction

  initial begin
    idle_inputs();
    rstn = 1'b0;
    q.delete(); m_ovf = 0; m_orph = 0;
    repeat (2) @(negedge clk);
    #1 check_outputs();
    rstn = 1'b1;

    // Idle after reset
    cycle(0, '0, 0, '0, '0);
    // Two grants, then two responses with all ready
    cycle(1, 4'b0100, 0, '0, '0);
    cycle(1, 4'b0001, 0, '0, '0);
    cycle(0, '0, 1, 32'hA, 4'hF);
    cycle(0, '0, 1, 32'hB, 4'hF);
    cycle(0, '0, 0, '0, '0);
    // Fill to full, overflow attempt, then pop together with acc at full
    for (int i = 0; i < 4; i++) cycle(1, rnd_gnt(), 0, '0, '0);
    cycle(1, 4'b1000, 0, '0, '0);
    cycle(1, 4'b0010, 1, 32'h11, 4'hF);
    cycle(0, '0, 0, '0, '0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 32'h20 + i, 4'hF);
    // Head 0010 stalls when its own ready is low, then pops
    cycle(1, 4'b0010, 0, '0, '0);
    cycle(0, '0, 1, 32'h33, 4'b1101);
    cycle(0, '0, 1, 32'h34, 4'b1111);
    cycle(0, '0, 0, '0, '0);
    // Steady push and pop across pointer wrap
    cycle(1, 4'b0001, 0, '0, '0);
    for (int i = 0; i < 10; i++) cycle(1, rnd_gnt(), 1, 32'h100 + i, 4'hF);
    cycle(0, '0, 1, 32'h200, 4'hF);
    // Orphan response, and a same-cycle push with a response that must stall without flagging
    cycle(1, 4'b0100, 1, 32'h300, 4'hF);
    cycle(0, '0, 1, 32'h301, 4'hF);
    cycle(0, '0, 1, 32'h302, 4'hF);
    // Mid-burst asynchronous reset
    cycle(1, 4'b1000, 0, '0, '0);
    cycle(1, 4'b0010, 1, 32'h400, 4'hF);
    acc_valid = 1; t_rsp_valid = 1;
    do_reset();
    cycle(0, '0, 0, '0, '0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit av, tv;
      logic [N-1:0] rdy;
      if (i == 300) do_reset();
      av  = ($urandom_range(0, 99) < ((q.size() == D) ? 10 : 55));
      tv  = ($urandom_range(0, 99) < ((q.size() == 0) ? 3 : 60));
      rdy = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'hF;
      cycle(av, rnd_gnt(), tv, $urandom, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
